// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer and its neighbours: decode/execute requests
// in, program-counter control out, PC value fed back.
interface fetch_sequencer_if #(
  parameter int addr_w = 16,
  parameter int cyc_w  = 16
);
  logic              start;
  logic              stall;
  logic              br_req;
  logic [addr_w-1:0] br_target;
  logic              halt_req;
  logic [addr_w-1:0] pc_addr;
  logic              pc_hold;
  logic              pc_load;
  logic [addr_w-1:0] pc_target;
  logic              fetch_valid;
  logic              flush;
  logic              done;
  logic [cyc_w-1:0]  cycle_cnt;

  // Requester side: drives control requests and the PC feedback.
  modport master (
    output start, stall, br_req, br_target, halt_req, pc_addr,
    input  pc_hold, pc_load, pc_target, fetch_valid, flush, done, cycle_cnt
  );

  // Sequencer side.
  modport slave (
    input  start, stall, br_req, br_target, halt_req, pc_addr,
    output pc_hold, pc_load, pc_target, fetch_valid, flush, done, cycle_cnt
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: steers the program counter through start-up load, normal
// advance, stall hold, taken-branch redirect with a one-cycle flush bubble,
// and halt. Outputs are a combinational decode of state, the pending-branch
// record and the current inputs so a branch redirects the PC on the same edge.
module fetch_sequencer #(
  parameter int                addr_w     = 16,
  parameter logic [addr_w-1:0] start_addr = '0,
  parameter int                cyc_w      = 16
) (
  input logic              clk,
  input logic              init,
  fetch_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_FLUSH,
    S_HALTED
  } state_t;

  state_t            state;
  logic              pend;
  logic [addr_w-1:0] pend_tgt;
  logic [cyc_w-1:0]  cnt;
  logic              latch_br;

  // Run-cycle counter step that sticks at all ones instead of wrapping.
  function automatic logic [cyc_w-1:0] sat_inc(input logic [cyc_w-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Output decode; init overrides everything with the reset values.
  always_comb begin
    bus.pc_hold     = 1'b1;
    bus.pc_load     = 1'b0;
    bus.pc_target   = '0;
    bus.fetch_valid = 1'b0;
    bus.flush       = 1'b0;
    bus.done        = 1'b0;
    bus.cycle_cnt   = init ? '0 : cnt;
    latch_br        = 1'b0;
    if (!init) begin
      case (state)
        S_LOAD: begin
          bus.pc_hold   = 1'b0;
          bus.pc_load   = 1'b1;
          bus.pc_target = start_addr;
        end
        S_RUN: begin
          if (bus.halt_req) begin
            bus.pc_hold = 1'b1;
          end else if (bus.stall) begin
            bus.pc_hold = 1'b1;
            latch_br    = bus.br_req;
          end else if (bus.br_req || pend) begin
            bus.pc_hold   = 1'b0;
            bus.pc_load   = 1'b1;
            bus.flush     = 1'b1;
            bus.pc_target = bus.br_req ? bus.br_target : pend_tgt;
          end else begin
            bus.pc_hold     = 1'b0;
            bus.fetch_valid = 1'b1;
          end
        end
        S_FLUSH: begin
          latch_br = bus.br_req && !bus.halt_req;
        end
        S_HALTED: begin
          bus.done = 1'b1;
        end
        default: begin
          bus.pc_hold = 1'b1;
        end
      endcase
    end
  end

  // Control state: FSM, pending-branch flag and saturating run-cycle counter.
  always_ff @(posedge clk) begin
    if (init) begin
      state <= S_IDLE;
      pend  <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state <= S_LOAD;
            cnt   <= '0;
          end
        end
        S_LOAD: begin
          state <= S_RUN;
          cnt   <= sat_inc(cnt);
        end
        S_RUN: begin
          cnt <= sat_inc(cnt);
          if (bus.halt_req) begin
            state <= S_HALTED;
            pend  <= 1'b0;
          end else if (bus.stall) begin
            if (bus.br_req) pend <= 1'b1;
          end else if (bus.br_req || pend) begin
            state <= S_FLUSH;
            pend  <= 1'b0;
          end
        end
        S_FLUSH: begin
          cnt <= sat_inc(cnt);
          if (bus.halt_req) begin
            state <= S_HALTED;
            pend  <= 1'b0;
          end else begin
            state <= S_RUN;
            if (bus.br_req) pend <= 1'b1;
          end
        end
        S_HALTED: begin
          state <= S_HALTED;
        end
        default: begin
          state <= S_IDLE;
          pend  <= 1'b0;
        end
      endcase
    end
  end

  // Pending branch target; a later request while pending overwrites it.
  always_ff @(posedge clk) begin
    if (!init && latch_br) pend_tgt <= bus.br_target;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the sequencing rules.
// A small program-counter plant driven by the DUT's outputs feeds pc_addr back.
module tb_fetch_sequencer;
  localparam int            AW    = 16;
  localparam int            CW    = 4;
  localparam logic [AW-1:0] START = '0;
  localparam int            CMAX  = (1 << CW) - 1;

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_RUN   = 2;
  localparam int M_FLUSH = 3;
  localparam int M_HALT  = 4;

  logic clk = 1'b0;
  logic init;
  int   checks = 0;
  int   failures = 0;

  fetch_sequencer_if #(.addr_w(AW), .cyc_w(CW)) bus ();

  fetch_sequencer #(.addr_w(AW), .start_addr(START), .cyc_w(CW)) dut (
    .clk (clk),
    .init(init),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model state
  int            m_phase;
  bit            m_pend;
  logic [AW-1:0] m_ptgt;
  int            m_cnt;
  // PC plant
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_nxt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit st, input bit sl, input bit br, input logic [AW-1:0] bt,
                      input bit hl, input bit in);
    bit            e_hold, e_load, e_fv, e_flush, e_done;
    logic [AW-1:0] e_tgt;
    int            e_cnt;
    bus.start     = st;
    bus.stall     = sl;
    bus.br_req    = br;
    bus.br_target = bt;
    bus.halt_req  = hl;
    bus.pc_addr   = pc;
    init          = in;
    #1;
    // Expected outputs from the sequencing rules.
    e_hold = 1; e_load = 0; e_fv = 0; e_flush = 0; e_done = 0; e_tgt = '0;
    e_cnt  = in ? 0 : m_cnt;
    if (!in) begin
      if (m_phase == M_LOAD) begin
        e_hold = 0; e_load = 1; e_tgt = START;
      end else if (m_phase == M_RUN && !hl && !sl) begin
        e_hold = 0;
        if (br || m_pend) begin
          e_load = 1; e_flush = 1; e_tgt = br ? bt : m_ptgt;
        end else begin
          e_fv = 1;
        end
      end else if (m_phase == M_HALT) begin
        e_done = 1;
      end
    end
    check("pc_hold", 32'(bus.pc_hold), 32'(e_hold));
    check("pc_load", 32'(bus.pc_load), 32'(e_load));
    check("fetch_valid", 32'(bus.fetch_valid), 32'(e_fv));
    check("flush", 32'(bus.flush), 32'(e_flush));
    check("done", 32'(bus.done), 32'(e_done));
    check("cycle_cnt", 32'(bus.cycle_cnt), 32'(e_cnt));
    if (in || e_load) check("pc_target", 32'(bus.pc_target), 32'(e_tgt));
    // PC plant reacts to what the DUT actually drives.
    if (bus.pc_load) pc_nxt = bus.pc_target;
    else if (!bus.pc_hold) pc_nxt = pc + 1'b1;
    else pc_nxt = pc;
    @(posedge clk);
    pc = pc_nxt;
    // Model transition.
    if (in) begin
      m_phase = M_IDLE; m_pend = 0; m_cnt = 0;
    end else begin
      if (m_phase == M_LOAD || m_phase == M_RUN || m_phase == M_FLUSH)
        m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
      case (m_phase)
        M_IDLE: if (st) begin m_phase = M_LOAD; m_cnt = 0; end
        M_LOAD: m_phase = M_RUN;
        M_RUN: begin
          if (hl) begin
            m_phase = M_HALT; m_pend = 0;
          end else if (sl) begin
            if (br) begin m_pend = 1; m_ptgt = bt; end
          end else if (br || m_pend) begin
            m_phase = M_FLUSH; m_pend = 0;
          end
        end
        M_FLUSH: begin
          if (hl) begin
            m_phase = M_HALT; m_pend = 0;
          end else begin
            m_phase = M_RUN;
            if (br) begin m_pend = 1; m_ptgt = bt; end
          end
        end
        default: m_phase = m_phase;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic idle_step();
    step(0, 0, 0, '0, 0, 0);
  endtask

  initial begin
    logic [AW-1:0] held;
    m_phase = M_IDLE; m_pend = 0; m_ptgt = '0; m_cnt = 0;
    pc = '0; pc_nxt = '0;

    // 1: reset, start, LOAD then sequential fetch from start_addr.
    step(0, 0, 0, '0, 0, 1);
    step(0, 0, 0, '0, 0, 1);
    step(1, 0, 0, '0, 0, 0);
    idle_step();
    for (int i = 0; i < 4; i++) begin
      check("t1_pc", 32'(pc), 32'(START) + 32'(i));
      if (i == 3) check("t1_cnt", 32'(bus.cycle_cnt), 32'd4);
      idle_step();
    end
    idle_step();

    // 2: branch at pc=5 to 0x40, one FLUSH bubble.
    check("t2_pc5", 32'(pc), 32'h5);
    step(0, 0, 1, 16'h0040, 0, 0);
    check("t2_pc_tgt", 32'(pc), 32'h40);
    idle_step();
    idle_step();
    check("t2_pc_adv", 32'(pc), 32'h41);

    // 3: stall three cycles with a branch in the first; redirect afterwards.
    held = pc;
    step(0, 1, 1, 16'h0080, 0, 0);
    step(0, 1, 0, '0, 0, 0);
    step(0, 1, 0, '0, 0, 0);
    check("t3_pc_held", 32'(pc), 32'(held));
    idle_step();
    check("t3_pc_tgt", 32'(pc), 32'h80);
    idle_step();
    idle_step();

    // 4: halt and branch together: halt wins, start ignored.
    held = pc;
    step(0, 0, 1, 16'h0010, 1, 0);
    step(1, 0, 0, '0, 0, 0);
    step(1, 0, 0, '0, 0, 0);
    idle_step();
    check("t4_pc_frozen", 32'(pc), 32'(held));

    // 5a: init while in FLUSH with a branch arriving; 5b: init with pend set.
    step(0, 0, 0, '0, 0, 1);
    step(1, 0, 0, '0, 0, 0);
    idle_step();
    idle_step();
    step(0, 0, 1, 16'h0020, 0, 0);
    step(0, 0, 1, 16'h0030, 0, 1);
    step(1, 0, 0, '0, 0, 0);
    idle_step();
    check("t5a_pc_start", 32'(pc), 32'(START));
    idle_step();
    step(0, 1, 1, 16'h0050, 0, 0);
    step(0, 0, 0, '0, 0, 1);
    step(0, 0, 0, '0, 0, 0);
    step(1, 0, 0, '0, 0, 0);
    idle_step();
    check("t5b_pc_start", 32'(pc), 32'(START));

    // 6: counter saturation and PC wrap-around.
    for (int i = 0; i < 20; i++) idle_step();
    check("t6_cnt_sat", 32'(bus.cycle_cnt), 32'(CMAX));
    step(0, 0, 1, 16'hFFFF, 0, 0);
    idle_step();
    check("t6_pc_ffff", 32'(pc), 32'hFFFF);
    idle_step();
    check("t6_pc_wrap", 32'(pc), 32'h0);
    idle_step();
    check("t6_pc_after", 32'(pc), 32'h1);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0),
           AW'($urandom),
           ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 79) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
